// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the seven-segment scan driver.
// Patterns are active-low {a,b,c,d,e,f,g} with segment a on bit 6.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  localparam logic [6:0] SEG_PATTERN [0:15] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_PATTERN[nib];
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Load handshake, display controls and board-pin outputs of the scan driver.
// The master side is the value source; the slave side is the driver itself.
interface seven_seg_scan_driver_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WIDTH  = 14
);
  logic              load;
  logic [WIDTH-1:0]  value;
  logic              hex_mode;
  logic              blank_lz;
  logic [DIGITS-1:0] dp_in;
  logic              busy;
  logic              overflow;
  logic [DIGITS-1:0] anode;
  logic [6:0]        seg;
  logic              dp;

  modport master (
    output load, value, hex_mode, blank_lz, dp_in,
    input  busy, overflow, anode, seg, dp
  );

  modport slave (
    input  load, value, hex_mode, blank_lz, dp_in,
    output busy, overflow, anode, seg, dp
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle, MSB first.
// ovf flags any non-zero nibble above the displayed digits, or a carry lost off the top.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  output logic                      done,
  output logic [4*(DIGITS+1)-1:0]   bcd,
  output logic                      ovf
);
  localparam int unsigned BCD_W = 4 * (DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             lost_q, lost_d;
  logic             last;

  assign last = run_q && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < int'(DIGITS) + 1; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    lost_d = lost_q;
    if (start) begin
      sh_d   = bin;
      bcd_d  = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
      lost_d = 1'b0;
    end else if (run_q) begin
      bcd_d  = {adj[BCD_W-2:0], sh_q[WIDTH-1]};
      sh_d   = {sh_q[WIDTH-2:0], 1'b0};
      // A bit shifted out of the top nibble means the value is far beyond range.
      lost_d = lost_q | adj[BCD_W-1];
      cnt_d  = cnt_q + 1'b1;
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      lost_q <= lost_d;
    end
  end

  assign done = last;
  assign bcd  = bcd_q;
  assign ovf  = lost_q | (bcd_q[BCD_W-1:4*DIGITS] != '0);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// N-digit multiplexed seven-segment driver: load handshake, decimal/hex display
// register, leading-zero blanking, scan prescaler and registered pin outputs.
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned WIDTH        = 14,
  parameter int unsigned REFRESH_BITS = 18
) (
  input logic                  clk,
  input logic                  rst,
  seven_seg_scan_driver_if.slave bus
);
  localparam int unsigned BCD_W = 4 * (DIGITS + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        val_q;
  logic                    hex_q;
  logic [4*DIGITS-1:0]     disp_q, hex_digits;
  logic                    ovf_q;
  logic [REFRESH_BITS-1:0] presc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DIGITS-1:0]       anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    busy, accept, conv_done, conv_ovf;
  logic [BCD_W-1:0]        conv_bcd;
  logic [DIGITS-1:0]       blank;
  logic                    zero_run, cur_blank, cur_dp;
  logic [3:0]              cur_nib;

  assign busy   = (state_q != IDLE);
  assign accept = bus.load && !busy;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept && !bus.hex_mode),
    .bin   (bus.value),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Hex digits are zero-extended; value bits beyond the displayed nibbles are dropped.
  for (genvar i = 0; i < int'(4 * DIGITS); i++) begin : g_hex
    if (i < int'(WIDTH)) begin : g_bit
      assign hex_digits[i] = val_q[i];
    end else begin : g_pad
      assign hex_digits[i] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = bus.hex_mode ? COMMIT : CONV;
      CONV:    if (conv_done) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      hex_q   <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        val_q <= bus.value;
        hex_q <= bus.hex_mode;
      end
      if (state_q == COMMIT) begin
        disp_q <= hex_q ? hex_digits : conv_bcd[4*DIGITS-1:0];
        ovf_q  <= hex_q ? 1'b0 : conv_ovf;
      end
    end
  end

  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_run = zero_run & (disp_q[4*k +: 4] == 4'd0);
      blank[k] = bus.blank_lz & ~ovf_q & zero_run;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    anode_d   = '1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib    = disp_q[4*k +: 4];
        cur_blank  = blank[k];
        cur_dp     = bus.dp_in[k];
        anode_d[k] = 1'b0;
      end
    end
    seg_d = ovf_q ? SEG_DASH : (cur_blank ? SEG_BLANK : seg_decode(cur_nib));
    dp_d  = ~cur_dp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (&presc_q) idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.overflow = ovf_q;
  assign bus.anode    = anode_q;
  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: expected digit patterns are queued at each load and compared
// over a full scan once the driver commits; a 3-digit instance checks index wrap.
module tb_seven_seg_scan_driver;

  typedef struct packed {
    logic [3:0][6:0] segs;
    logic            ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seven_seg_scan_driver_if #(.DIGITS(4), .WIDTH(14)) ifc ();
  seven_seg_scan_driver_if #(.DIGITS(3), .WIDTH(14)) ifc3 ();

  seven_seg_scan_driver #(.DIGITS(4), .WIDTH(14), .REFRESH_BITS(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  seven_seg_scan_driver #(.DIGITS(3), .WIDTH(14), .REFRESH_BITS(2)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (ifc3)
  );

  // Lit-segment patterns {a..g}, inverted for the active-low pins.
  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h7E; 4'h1: lit = 7'h30; 4'h2: lit = 7'h6D; 4'h3: lit = 7'h79;
      4'h4: lit = 7'h33; 4'h5: lit = 7'h5B; 4'h6: lit = 7'h5F; 4'h7: lit = 7'h70;
      4'h8: lit = 7'h7F; 4'h9: lit = 7'h7B; 4'hA: lit = 7'h77; 4'hB: lit = 7'h1F;
      4'hC: lit = 7'h4E; 4'hD: lit = 7'h3D; 4'hE: lit = 7'h4F; default: lit = 7'h47;
    endcase
    return ~lit;
  endfunction

  function automatic exp_t model(input logic [13:0] v, input logic hex, input logic blz);
    exp_t        e;
    logic [15:0] vv;
    logic [3:0]  nib [4];
    int          tmp;
    bit          run;
    vv    = {2'b00, v};
    tmp   = int'(v);
    e.ovf = !hex && (tmp > 9999);
    for (int k = 0; k < 4; k++) begin
      nib[k] = hex ? vv[4*k +: 4] : 4'(tmp % 10);
      tmp    = tmp / 10;
    end
    run = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      run = run && (nib[k] == 4'd0);
      if (e.ovf)                  e.segs[k] = 7'b1111110;
      else if (blz && run && k > 0) e.segs[k] = 7'h7F;
      else                        e.segs[k] = exp_seg(nib[k]);
    end
    return e;
  endfunction

  task automatic drive_load(input logic [13:0] v, input logic hex, input bit push);
    @(negedge clk);
    ifc.value    = v;
    ifc.hex_mode = hex;
    ifc.load     = 1'b1;
    if (push) sb.push_back(model(v, hex, ifc.blank_lz));
    @(negedge clk);
    ifc.load = 1'b0;
  endtask

  // Scoreboard monitor: each commit pops one expectation and checks a full scan.
  initial begin : monitor
    exp_t       cur;
    logic [3:0] seen;
    logic [3:0] an;
    forever begin
      @(negedge ifc.busy);
      if (rst) continue;
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_commit: got commit, expected none queued");
        continue;
      end
      cur = sb.pop_front();
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (ifc.overflow !== cur.ovf) begin
        n_fail++;
        $display("FAIL sb_overflow: got %b expected %b", ifc.overflow, cur.ovf);
      end
      seen = '0;
      for (int c = 0; c < 40 && seen != 4'hF; c++) begin
        for (int k = 0; k < 4; k++) begin
          an = ~(4'b0001 << k);
          if (ifc.anode === an && !seen[k]) begin
            seen[k] = 1'b1;
            n_tests++;
            if (ifc.seg !== cur.segs[k]) begin
              n_fail++;
              $display("FAIL sb_seg digit %0d: got %b expected %b", k, ifc.seg, cur.segs[k]);
            end
            n_tests++;
            if (ifc.dp !== ~ifc.dp_in[k]) begin
              n_fail++;
              $display("FAIL sb_dp digit %0d: got %b expected %b", k, ifc.dp, ~ifc.dp_in[k]);
            end
          end
        end
        @(negedge clk);
      end
      n_tests++;
      if (seen != 4'hF) begin
        n_fail++;
        $display("FAIL sb_scan_cover: got digits %b expected 1111", seen);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests += 5;
    if (ifc.anode !== 4'hF)     begin n_fail++; $display("FAIL rst_anode: got %b expected 1111", ifc.anode); end
    if (ifc.seg !== 7'h7F)      begin n_fail++; $display("FAIL rst_seg: got %h expected 7f", ifc.seg); end
    if (ifc.dp !== 1'b1)        begin n_fail++; $display("FAIL rst_dp: got %b expected 1", ifc.dp); end
    if (ifc.busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b expected 0", ifc.busy); end
    if (ifc.overflow !== 1'b0)  begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", ifc.overflow); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests += 2;
    if (ifc.anode !== 4'b1110)  begin n_fail++; $display("FAIL rel_anode: got %b expected 1110", ifc.anode); end
    if (ifc.seg !== 7'b0000001) begin n_fail++; $display("FAIL rel_seg: got %b expected 0000001", ifc.seg); end
  endtask

  task automatic test_decimal();
    int n = 0;
    drive_load(14'd1234, 1'b0, 1'b1);
    for (int c = 0; c < 100 && ifc.busy === 1'b1; c++) begin n++; @(negedge clk); end
    n_tests++;
    if (n != 15) begin n_fail++; $display("FAIL dec_busy_len: got %0d expected 15", n); end
    repeat (45) @(negedge clk);
  endtask

  task automatic test_overflow();
    int n = 0;
    drive_load(14'd10000, 1'b0, 1'b1);
    for (int c = 0; c < 100 && ifc.busy === 1'b1; c++) begin n++; @(negedge clk); end
    repeat (45) @(negedge clk);
    n_tests++;
    if (ifc.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ifc.overflow); end
    ifc.blank_lz = 1'b1;
    drive_load(14'd42, 1'b0, 1'b1);
    for (int c = 0; c < 100 && ifc.busy === 1'b1; c++) @(negedge clk);
    repeat (45) @(negedge clk);
    n_tests++;
    if (ifc.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", ifc.overflow); end
  endtask

  task automatic test_hex();
    int n = 0;
    drive_load(14'h2BEF, 1'b1, 1'b1);
    for (int c = 0; c < 100 && ifc.busy === 1'b1; c++) begin n++; @(negedge clk); end
    n_tests++;
    if (n != 1) begin n_fail++; $display("FAIL hex_busy_len: got %0d expected 1", n); end
    repeat (45) @(negedge clk);
    n_tests++;
    if (ifc.overflow !== 1'b0) begin n_fail++; $display("FAIL hex_ovf: got %b expected 0", ifc.overflow); end
  endtask

  task automatic test_ignore_busy();
    ifc.blank_lz = 1'b0;
    ifc.dp_in    = 4'b0100;
    drive_load(14'd1234, 1'b0, 1'b1);
    ifc.value = 14'd5678;
    ifc.load  = 1'b1;
    @(negedge clk);
    ifc.load = 1'b0;
    for (int c = 0; c < 100 && ifc.busy === 1'b1; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_tests++;
    if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy: got busy %b expected 0", ifc.busy); end
    repeat (45) @(negedge clk);
    ifc.dp_in = 4'b0000;
  endtask

  task automatic test_reset_abort();
    bit found = 1'b0;
    ifc.blank_lz = 1'b1;
    drive_load(14'd9999, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests += 2;
    if (ifc.busy !== 1'b0)     begin n_fail++; $display("FAIL abort_busy: got %b expected 0", ifc.busy); end
    if (ifc.anode !== 4'hF)    begin n_fail++; $display("FAIL abort_anode: got %b expected 1111", ifc.anode); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests += 2;
    if (ifc.anode !== 4'b1110) begin n_fail++; $display("FAIL abort_anode0: got %b expected 1110", ifc.anode); end
    if (ifc.seg !== 7'b0000001) begin n_fail++; $display("FAIL abort_seg0: got %b expected 0000001", ifc.seg); end
    for (int c = 0; c < 40; c++) begin
      if (ifc.anode === 4'b0111 && !found) begin
        found = 1'b1;
        n_tests++;
        if (ifc.seg !== 7'h7F) begin n_fail++; $display("FAIL abort_seg3: got %h expected 7f", ifc.seg); end
      end
      @(negedge clk);
    end
    n_tests += 2;
    if (!found)                begin n_fail++; $display("FAIL abort_scan: got no digit 3 expected seen"); end
    if (ifc.busy !== 1'b0)     begin n_fail++; $display("FAIL abort_idle: got busy %b expected 0", ifc.busy); end
  endtask

  task automatic test_scan_wrap3();
    logic [2:0] exp_seq [3];
    logic [2:0] prev;
    int         got = 0;
    bit         sync = 1'b0;
    exp_seq[0] = 3'b101;
    exp_seq[1] = 3'b011;
    exp_seq[2] = 3'b110;
    for (int c = 0; c < 40 && !sync; c++) begin
      @(negedge clk);
      if (ifc3.anode === 3'b110) sync = 1'b1;
    end
    prev = ifc3.anode;
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(negedge clk);
      if (ifc3.anode !== prev) begin
        prev = ifc3.anode;
        n_tests++;
        if (ifc3.anode !== exp_seq[got]) begin
          n_fail++;
          $display("FAIL wrap3_step %0d: got %b expected %b", got, ifc3.anode, exp_seq[got]);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 3) begin n_fail++; $display("FAIL wrap3_steps: got %0d expected 3", got); end
  endtask

  initial begin
    ifc.load      = 1'b0;
    ifc.value     = '0;
    ifc.hex_mode  = 1'b0;
    ifc.blank_lz  = 1'b0;
    ifc.dp_in     = '0;
    ifc3.load     = 1'b0;
    ifc3.value    = '0;
    ifc3.hex_mode = 1'b0;
    ifc3.blank_lz = 1'b0;
    ifc3.dp_in    = '0;
    #1 rst = 1'b1;
    test_reset();
    test_decimal();
    test_overflow();
    test_hex();
    test_ignore_busy();
    test_reset_abort();
    test_scan_wrap3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
